matmul_host_ctrl: RTL

Host-side companion to the matmul core.
- Accepts a valid/ready input stream and writes X (row-major), then Y (row-major), into the X and Y memories.
- Pulses mm_start and waits for mm_done.
- Reads the Z memory back and emits it as a valid/ready output stream, marking the last element.
- Sits between the external stream fabric and the three matmul memories. This block is the writer for the ports the core reads and the reader for the port the core writes.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_z_drain.sv | 84 ++++++++
 rtl/matmul_host_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul core and its host-side controller.
package matmul_pkg;

   localparam int MM_DATA_WIDTH  = 32;
   localparam int MM_ADDR_WIDTH  = 6;
   localparam int MM_MATRIX_SIZE = 8;

   typedef enum logic [2:0] {
      LOAD_X,
      LOAD_Y,
      START,
      WAIT,
      RD,
      CAP,
      OUT
   } host_state_t;

   function automatic int elems(input int n);
      return n * n;
   endfunction

endpackage

// File: rtl/matmul_z_drain.sv
// Z memory to output stream reader: one RAM read, one capture, then a held
// valid/ready beat per element, with out_last on the final element.
module matmul_z_drain
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH  = MM_DATA_WIDTH,
   parameter int ADDR_WIDTH  = MM_ADDR_WIDTH,
   parameter int MATRIX_SIZE = MM_MATRIX_SIZE
) (
   input  logic                  clock,
   input  logic                  reset,
   input  host_state_t           state_i,
   output host_state_t           state_next_o,
   input  logic [DATA_WIDTH-1:0] z_dout_i,
   output logic [ADDR_WIDTH-1:0] z_addr_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_last_o,
   output logic                  job_done_o
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(elems(MATRIX_SIZE) - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   always_comb begin
      cnt_d        = cnt_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      state_next_o = state_i;
      job_done_o   = 1'b0;
      case (state_i)
         RD: state_next_o = CAP;
         CAP: begin
            // z_dout reflects the address presented during RD
            out_data_d   = z_dout_i;
            out_valid_d  = 1'b1;
            out_last_d   = (cnt_q == CNT_LAST);
            state_next_o = OUT;
         end
         OUT: begin
            if (out_valid_q && out_ready_i) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (out_last_q) begin
                  job_done_o   = 1'b1;
                  cnt_d        = '0;
                  state_next_o = LOAD_X;
               end else begin
                  cnt_d        = cnt_q + CW'(1);
                  state_next_o = RD;
               end
            end
         end
         default: ;
      endcase
   end

   assign z_addr_o    = cnt_q[ADDR_WIDTH-1:0];
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;

endmodule

// File: rtl/matmul_host_ctrl.sv
// Host-side sequencer for the matmul core: streams X then Y into their RAMs,
// kicks the core, waits for done and hands the Z readback to matmul_z_drain.
module matmul_host_ctrl
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH  = MM_DATA_WIDTH,
   parameter int ADDR_WIDTH  = MM_ADDR_WIDTH,
   parameter int MATRIX_SIZE = MM_MATRIX_SIZE
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [ADDR_WIDTH-1:0] x_addr,
   output logic [DATA_WIDTH-1:0] x_din,
   output logic                  x_wr_en,
   output logic [ADDR_WIDTH-1:0] y_addr,
   output logic [DATA_WIDTH-1:0] y_din,
   output logic                  y_wr_en,
   output logic [ADDR_WIDTH-1:0] z_addr,
   input  logic [DATA_WIDTH-1:0] z_dout,
   output logic                  mm_start,
   input  logic                  mm_done,
   output logic                  busy,
   output logic                  job_done
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(elems(MATRIX_SIZE) - 1);

   host_state_t   state_q, state_d, drain_next;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          guard_q, guard_d;
   logic          last_elem;

   assign last_elem = (cnt_q == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LOAD_X;
         cnt_q   <= '0;
         guard_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         guard_q <= guard_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      guard_d  = guard_q;
      in_ready = 1'b0;
      x_addr   = '0;
      x_wr_en  = 1'b0;
      y_addr   = '0;
      y_wr_en  = 1'b0;
      mm_start = 1'b0;
      case (state_q)
         LOAD_X: begin
            in_ready = 1'b1;
            x_addr   = cnt_q[ADDR_WIDTH-1:0];
            x_wr_en  = in_valid;
            if (in_valid) begin
               if (last_elem) begin
                  cnt_d   = '0;
                  state_d = LOAD_Y;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         LOAD_Y: begin
            in_ready = 1'b1;
            y_addr   = cnt_q[ADDR_WIDTH-1:0];
            y_wr_en  = in_valid;
            if (in_valid) begin
               if (last_elem) begin
                  cnt_d   = '0;
                  state_d = START;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         START: begin
            mm_start = 1'b1;
            guard_d  = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            // The core only drops a done left over from the previous job one
            // cycle after seeing start, so the first WAIT cycle is blind.
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (mm_done) begin
               state_d = RD;
            end
         end
         RD, CAP, OUT: state_d = drain_next;
         default: state_d = LOAD_X;
      endcase
   end

   assign x_din = in_data;
   assign y_din = in_data;
   assign busy  = (state_q != LOAD_X);

   matmul_z_drain #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MATRIX_SIZE(MATRIX_SIZE)
   ) u_drain (
      .clock       (clock),
      .reset       (reset),
      .state_i     (state_q),
      .state_next_o(drain_next),
      .z_dout_i    (z_dout),
      .z_addr_o    (z_addr),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_last_o  (out_last),
      .job_done_o  (job_done)
   );

endmodule
